// File: rtl/usb_rw_responder_if.sv
// Transaction-level link between the device protocol FSM (master) and the
// page read/write responder (slave).
interface usb_rw_responder_if;
  logic        tran_valid;
  logic        tran_in;
  logic [6:0]  tran_addr;
  logic [3:0]  tran_endp;
  logic [63:0] rx_data;
  logic        rx_bad;
  logic        tran_ack;
  logic        tran_stall;
  logic        tx_valid;
  logic [63:0] tx_data;
  logic        tx_ready;
  logic        wr_done;
  logic        rd_done;
  logic        timeout;

  modport master (
    output tran_valid, tran_in, tran_addr, tran_endp, rx_data, rx_bad, tx_ready,
    input  tran_ack, tran_stall, tx_valid, tx_data, wr_done, rd_done, timeout
  );

  modport slave (
    input  tran_valid, tran_in, tran_addr, tran_endp, rx_data, rx_bad, tx_ready,
    output tran_ack, tran_stall, tx_valid, tx_data, wr_done, rd_done, timeout
  );
endinterface

// File: rtl/usb_rw_responder.sv
// Thumb-drive side of the page read/write protocol: address latch, 64-bit page
// memory, read/write execution. Optional statistics counters via USB_RW_STATS_EN.
module usb_rw_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'd5,
  parameter logic [3:0] ADDR_ENDP = 4'd4,
  parameter logic [3:0] DATA_ENDP = 4'd8,
  parameter int         MEM_DEPTH = 256,
  parameter int         TIMEOUT   = 1024
) (
  input  logic                 clk,
  input  logic                 rst_L,
  usb_rw_responder_if.slave    bus
`ifdef USB_RW_STATS_EN
  ,
  output logic [15:0]          stat_wr_cnt,
  output logic [15:0]          stat_rd_cnt,
  output logic [15:0]          stat_err_cnt
`endif
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [16:0]      DEPTH_LIM = 17'(MEM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR_HELD,
    S_READ_FETCH,
    S_READ_SEND
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [IDX_W-1:0]   r_page;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ack;
  logic               r_stall;
  logic               r_wr_pend;
  logic               r_wr_done;
  logic               r_rd_done;
  logic               r_timeout;
  logic               r_tx_valid;
  logic [63:0]        r_tx_data;
  logic [63:0]        mem [MEM_DEPTH];

  logic w_hit;
  logic w_page_ok;
  logic w_addr_out;
  logic w_data_out;
  logic w_data_in;
  logic w_ack;
  logic w_stall;
  logic w_mem_we;
  logic w_page_ld;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_rd_done;
  logic w_timeout;
  logic w_fetch;

  assign w_hit      = bus.tran_valid && (bus.tran_addr == DEV_ADDR);
  assign w_page_ok  = ({1'b0, bus.rx_data[15:0]} < DEPTH_LIM);
  assign w_addr_out = !bus.tran_in && (bus.tran_endp == ADDR_ENDP);
  assign w_data_out = !bus.tran_in && (bus.tran_endp == DATA_ENDP);
  assign w_data_in  =  bus.tran_in && (bus.tran_endp == DATA_ENDP);

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    w_next    = r_state;
    w_ack     = 1'b0;
    w_stall   = 1'b0;
    w_mem_we  = 1'b0;
    w_page_ld = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_rd_done = 1'b0;
    w_timeout = 1'b0;
    w_fetch   = 1'b0;

    if (bus.rx_bad) begin
      // An aborted transfer overrides any token presented in the same cycle.
      w_next    = S_IDLE;
      w_cnt_clr = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            if (w_addr_out && w_page_ok) begin
              w_page_ld = 1'b1;
              w_ack     = 1'b1;
              w_cnt_clr = 1'b1;
              w_next    = S_ADDR_HELD;
            end else begin
              w_stall = 1'b1;
            end
          end
        end

        S_ADDR_HELD: begin
          if (w_hit) begin
            if (w_data_out) begin
              w_mem_we = 1'b1;
              w_ack    = 1'b1;
              w_next   = S_IDLE;
            end else if (w_data_in) begin
              w_ack  = 1'b1;
              w_next = S_READ_FETCH;
            end else if (w_addr_out && w_page_ok) begin
              w_page_ld = 1'b1;
              w_ack     = 1'b1;
              w_cnt_clr = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_next  = S_IDLE;
            end
          end else if (r_cnt == CNT_LAST) begin
            w_timeout = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end

        S_READ_FETCH: begin
          w_stall = w_hit;
          w_fetch = 1'b1;
          w_next  = S_READ_SEND;
        end

        S_READ_SEND: begin
          w_stall = w_hit;
          if (bus.tx_ready) begin
            w_rd_done = 1'b1;
            w_next    = S_IDLE;
          end
        end

        default: w_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state    <= S_IDLE;
      r_page     <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_stall    <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_timeout  <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_ack      <= w_ack;
      r_stall    <= w_stall;
      r_wr_pend  <= w_mem_we;
      r_wr_done  <= r_wr_pend;
      r_rd_done  <= w_rd_done;
      r_timeout  <= w_timeout;
      r_tx_valid <= (w_next == S_READ_SEND);
      if (w_page_ld) r_page <= bus.rx_data[IDX_W-1:0];
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CNT_W'(1);
      if (w_fetch) r_tx_data <= mem[r_page];
    end
  end

  // NOTE: the page array carries no reset so it maps onto plain RAM; its
  // contents survive rst_L.
  always_ff @(posedge clk) begin
    if (w_mem_we) mem[r_page] <= bus.rx_data;
  end

  assign bus.tran_ack   = r_ack;
  assign bus.tran_stall = r_stall;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.wr_done    = r_wr_done;
  assign bus.rd_done    = r_rd_done;
  assign bus.timeout    = r_timeout;

`ifdef USB_RW_STATS_EN
  logic [15:0] r_stat_wr;
  logic [15:0] r_stat_rd;
  logic [15:0] r_stat_err;
  logic        w_err;

  // Stall, timeout and abort in one cycle still count as a single error.
  assign w_err = w_stall || w_timeout || bus.rx_bad;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_stat_wr  <= '0;
      r_stat_rd  <= '0;
      r_stat_err <= '0;
    end else begin
      if (r_wr_done && (r_stat_wr  != 16'hFFFF)) r_stat_wr  <= r_stat_wr  + 16'd1;
      if (r_rd_done && (r_stat_rd  != 16'hFFFF)) r_stat_rd  <= r_stat_rd  + 16'd1;
      if (w_err     && (r_stat_err != 16'hFFFF)) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_wr_cnt  = r_stat_wr;
  assign stat_rd_cnt  = r_stat_rd;
  assign stat_err_cnt = r_stat_err;
`endif

endmodule

// File: tb/tb_usb_rw_responder.sv
// Directed bench for usb_rw_responder: a token/response vector table plus
// hand-written read, timeout and reset sequences.
module tb_usb_rw_responder;
  localparam int TIMEOUT = 1024;

  logic clk   = 1'b0;
  logic rst_L = 1'b0;

  usb_rw_responder_if bus ();

`ifdef USB_RW_STATS_EN
  logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

  usb_rw_responder #(
    .DEV_ADDR (7'd5),
    .ADDR_ENDP(4'd4),
    .DATA_ENDP(4'd8),
    .MEM_DEPTH(256),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_L(rst_L),
    .bus  (bus)
`ifdef USB_RW_STATS_EN
    ,
    .stat_wr_cnt (stat_wr_cnt),
    .stat_rd_cnt (stat_rd_cnt),
    .stat_err_cnt(stat_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        v;
    logic        in;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [63:0] data;
    logic        bad;
    logic        e_ack;
    logic        e_stall;
    logic        e_wr;
  } vec_t;

  vec_t vecs [24];

  function automatic vec_t mk(input logic v, input logic in, input logic [6:0] addr,
                              input logic [3:0] endp, input logic [63:0] data,
                              input logic bad, input logic e_ack, input logic e_stall,
                              input logic e_wr);
    vec_t r;
    r.v = v; r.in = in; r.addr = addr; r.endp = endp; r.data = data; r.bad = bad;
    r.e_ack = e_ack; r.e_stall = e_stall; r.e_wr = e_wr;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic in, input logic [6:0] addr,
                       input logic [3:0] endp, input logic [63:0] data, input logic bad);
    bus.tran_valid = v;
    bus.tran_in    = in;
    bus.tran_addr  = addr;
    bus.tran_endp  = endp;
    bus.rx_data    = data;
    bus.rx_bad     = bad;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 7'd0, 4'd0, 64'd0, 1'b0);
  endtask

  // Address phase, IN token, optional hold with a stalled token and a foreign token.
  task automatic read_page(input logic [15:0] page, input logic [63:0] exp,
                           input int hold, input logic poke);
    drive(1'b1, 1'b0, 7'd5, 4'd4, {48'd0, page}, 1'b0);
    tick;
    check("rd_addr_ack", bus.tran_ack, 1);
    drive(1'b1, 1'b1, 7'd5, 4'd8, 64'd0, 1'b0);
    tick;
    check("rd_in_ack", bus.tran_ack, 1);
    check("rd_txv_early", bus.tx_valid, 0);
    idle;
    tick;
    check("rd_txv_lat2", bus.tx_valid, 1);
    check("rd_tx_data", bus.tx_data, exp);
    for (int i = 0; i < hold; i++) begin
      if (poke && i == 1)      drive(1'b1, 1'b1, 7'd5, 4'd8, 64'd0, 1'b0);
      else if (poke && i == 2) drive(1'b1, 1'b1, 7'd3, 4'd8, 64'd0, 1'b0);
      else                     idle;
      tick;
      check("rd_hold_txv", bus.tx_valid, 1);
      check("rd_hold_data", bus.tx_data, exp);
      check("rd_hold_stall", bus.tran_stall, (poke && i == 1) ? 1 : 0);
      check("rd_hold_done", bus.rd_done, 0);
    end
    idle;
    bus.tx_ready = 1'b1;
    tick;
    bus.tx_ready = 1'b0;
    check("rd_done_pulse", bus.rd_done, 1);
    check("rd_txv_drop", bus.tx_valid, 0);
    tick;
    check("rd_done_end", bus.rd_done, 0);
    drive(1'b1, 1'b1, 7'd5, 4'd8, 64'd0, 1'b0);
    tick;
    check("rd_back_idle", bus.tran_stall, 1);
    idle;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    logic seen;

    vecs[0]  = mk(1, 0, 7'd5, 4'd4, 64'h12,                  0, 1, 0, 0);
    vecs[1]  = mk(1, 0, 7'd5, 4'd8, 64'hDEADBEEF_CAFEF00D,   0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 7'd0, 4'd0, 64'd0,                   0, 0, 0, 1);
    vecs[3]  = mk(0, 0, 7'd0, 4'd0, 64'd0,                   0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 7'd3, 4'd4, 64'h40,                  0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 7'd5, 4'd4, 64'h40,                  0, 1, 0, 0);
    vecs[6]  = mk(1, 1, 7'd3, 4'd8, 64'd0,                   0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 7'd5, 4'd8, 64'h11223344_55667788,   0, 1, 0, 0);
    vecs[8]  = mk(1, 0, 7'd3, 4'd8, 64'hFFFF,                0, 0, 0, 1);
    vecs[9]  = mk(1, 0, 7'd5, 4'd4, 64'h0100,                0, 0, 1, 0);
    vecs[10] = mk(1, 0, 7'd5, 4'd8, 64'h1,                   0, 0, 1, 0);
    vecs[11] = mk(1, 0, 7'd5, 4'd4, 64'h00FF,                0, 1, 0, 0);
    vecs[12] = mk(1, 0, 7'd5, 4'd8, 64'hA5A5A5A5_5A5A5A5A,   0, 1, 0, 0);
    vecs[13] = mk(0, 0, 7'd0, 4'd0, 64'd0,                   0, 0, 0, 1);
    vecs[14] = mk(1, 0, 7'd5, 4'd4, 64'h12,                  0, 1, 0, 0);
    vecs[15] = mk(1, 0, 7'd5, 4'd8, 64'h0BAD_0BAD,           1, 0, 0, 0);
    vecs[16] = mk(0, 0, 7'd0, 4'd0, 64'd0,                   0, 0, 0, 0);
    vecs[17] = mk(1, 0, 7'd5, 4'd8, 64'h2,                   0, 0, 1, 0);
    vecs[18] = mk(1, 0, 7'd5, 4'd4, 64'h40,                  0, 1, 0, 0);
    vecs[19] = mk(1, 0, 7'd5, 4'd2, 64'd0,                   0, 0, 1, 0);
    vecs[20] = mk(1, 1, 7'd5, 4'd8, 64'd0,                   0, 0, 1, 0);
    vecs[21] = mk(1, 0, 7'd5, 4'd4, 64'h05,                  0, 1, 0, 0);
    vecs[22] = mk(1, 0, 7'd5, 4'd4, 64'h0200,                0, 0, 1, 0);
    vecs[23] = mk(1, 1, 7'd5, 4'd8, 64'd0,                   0, 0, 1, 0);

    idle;
    bus.tx_ready = 1'b0;
    rst_L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", bus.tran_ack, 0);
    check("rst_stall", bus.tran_stall, 0);
    check("rst_txv", bus.tx_valid, 0);
    check("rst_txd", bus.tx_data, 0);
    check("rst_wr_done", bus.wr_done, 0);
    check("rst_rd_done", bus.rd_done, 0);
    check("rst_timeout", bus.timeout, 0);
    rst_L = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].v, vecs[i].in, vecs[i].addr, vecs[i].endp, vecs[i].data, vecs[i].bad);
      tick;
      check($sformatf("vec%0d_ack", i),   bus.tran_ack,   vecs[i].e_ack);
      check($sformatf("vec%0d_stall", i), bus.tran_stall, vecs[i].e_stall);
      check($sformatf("vec%0d_wr", i),    bus.wr_done,    vecs[i].e_wr);
      check($sformatf("vec%0d_txv", i),   bus.tx_valid,   0);
      check($sformatf("vec%0d_to", i),    bus.timeout,    0);
    end
    idle;
    tick;

    read_page(16'h0012, 64'hDEADBEEF_CAFEF00D, 5, 1'b0);
    read_page(16'h0040, 64'h11223344_55667788, 5, 1'b1);
    read_page(16'h00FF, 64'hA5A5A5A5_5A5A5A5A, 2, 1'b0);

    drive(1'b1, 1'b0, 7'd5, 4'd4, 64'h12, 1'b0);
    tick;
    check("to_addr_ack", bus.tran_ack, 1);
    idle;
    n = 0;
    seen = 1'b0;
    while (!seen && n < TIMEOUT + 8) begin
      tick;
      n++;
      if (bus.timeout) seen = 1'b1;
    end
    check("to_seen", seen, 1);
    check("to_cycles", n, TIMEOUT);
    tick;
    check("to_single", bus.timeout, 0);
    drive(1'b1, 1'b1, 7'd5, 4'd8, 64'd0, 1'b0);
    tick;
    check("to_in_stall", bus.tran_stall, 1);
    check("to_in_noack", bus.tran_ack, 0);
    idle;
    tick;

    drive(1'b1, 1'b0, 7'd5, 4'd4, 64'h40, 1'b0);
    tick;
    drive(1'b1, 1'b1, 7'd5, 4'd8, 64'd0, 1'b0);
    tick;
    idle;
    tick;
    check("rst_mid_txv_pre", bus.tx_valid, 1);
    #3;
    rst_L = 1'b0;
    #1;
    check("rst_mid_txv", bus.tx_valid, 0);
    check("rst_mid_txd", bus.tx_data, 0);
    #2;
    rst_L = 1'b1;
    tick;
    read_page(16'h0012, 64'hDEADBEEF_CAFEF00D, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/usb_rw_responder.md
Name: usb_rw_responder

Overview:
- Device-side counterpart of the host read/write FSM; models the thumb-drive end of the page read/write protocol.
- Consumes decoded transactions from the device protocol FSM, latches the page address sent on the address endpoint, and executes a write or read of a 64-bit page on the data endpoint.
- Holds the page memory internally and returns read data to the device protocol FSM for transmission in the IN data phase.

Parameters:
- DEV_ADDR, 7'd5: device address this block responds to.
- ADDR_ENDP, 4'd4: endpoint carrying the page address (OUT only).
- DATA_ENDP, 4'd8: endpoint carrying page data (OUT = write, IN = read).
- MEM_DEPTH, 256: number of 64-bit pages; index width is clog2(MEM_DEPTH).
- TIMEOUT, 1024: idle cycles allowed between the address phase and the data phase.

Ports:
- clk  in  1  system clock
- rst_L  in  1  asynchronous active-low reset
- tran_valid  in  1  protocol FSM presents a decoded token plus data for one cycle
- tran_in  in  1  1 = IN token, 0 = OUT token
- tran_addr  in  7  token device address
- tran_endp  in  4  token endpoint
- rx_data  in  64  OUT data payload; valid with tran_valid when tran_in = 0
- rx_bad  in  1  protocol FSM aborted the transfer (CRC/timeout/cancel)
- tran_ack  out  1  one-cycle accept of the current token
- tran_stall  out  1  one-cycle reject of the current token
- tx_valid  out  1  read data available for the IN data phase
- tx_data  out  64  read data
- tx_ready  in  1  protocol FSM has sent tx_data
- wr_done  out  1  one-cycle pulse after a page is written
- rd_done  out  1  one-cycle pulse after read data is consumed
- timeout  out  1  one-cycle pulse when the data phase does not arrive in time

Behaviour:
- Reset (async, rst_L = 0): state IDLE; all outputs 0; page register 0; timeout counter 0. Memory contents are not reset.
- Tokens with tran_addr != DEV_ADDR are ignored in every state: no ack, no stall, no state change.
- The response to a token (tran_ack or tran_stall) is registered and asserts the cycle after tran_valid. At most one of tran_ack and tran_stall is high in any cycle.
- FSM states: IDLE, ADDR_HELD, READ_FETCH, READ_SEND.
- IDLE:
  - OUT to ADDR_ENDP with rx_data[15:0] < MEM_DEPTH: latch page = rx_data[15:0]; ack; go to ADDR_HELD; clear the counter.
  - Page >= MEM_DEPTH: stall; stay in IDLE.
  - Any other token to DEV_ADDR: stall; stay in IDLE.
- ADDR_HELD:
  - OUT to DATA_ENDP: mem[page] <= rx_data on the same edge; ack; wr_done the following cycle; go to IDLE.
  - IN to DATA_ENDP: ack; go to READ_FETCH.
  - OUT to ADDR_ENDP: re-latch the page (same range check; a bad page stalls and goes to IDLE); clear the counter.
  - Any other token to DEV_ADDR: stall; go to IDLE.
  - Counter increments each cycle without a matching token. When it reaches TIMEOUT-1: pulse timeout; go to IDLE.
- READ_FETCH: synchronous memory read of mem[page] into the tx_data register; go to READ_SEND. IN latency is 2 cycles from tran_valid to tx_valid.
- READ_SEND:
  - tx_valid = 1; tx_data is held stable until tx_ready.
  - On tx_ready: drop tx_valid the next cycle; pulse rd_done; go to IDLE.
  - Tokens arriving in READ_FETCH or READ_SEND are stalled; the state is unchanged.
- rx_bad in any state: go to IDLE next cycle; tx_valid drops; no memory write occurs even if tran_valid is high in the same cycle (rx_bad wins); no ack or done pulse.
- Write then read of the same page returns the written data. No read-during-write hazard exists because the FSM serialises the two.

Optional Feature:
- Macro: USB_RW_STATS_EN.
- When defined: adds output ports stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_err_cnt[15:0].
  - stat_wr_cnt increments on wr_done; stat_rd_cnt increments on rd_done.
  - stat_err_cnt increments on a stall, a timeout or rx_bad, at most +1 per cycle.
  - All counters saturate at 16'hFFFF and reset to 0.
- When not defined: the ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- OUT addr 5/endp 4 with data 0x0012, then OUT endp 8 with data 0xDEADBEEF_CAFEF00D -> two acks, wr_done one cycle after the second ack; mem[0x12] holds the value.
- Same address phase, then IN endp 8 -> ack, tx_valid 2 cycles after the token with tx_data = 0xDEADBEEF_CAFEF00D; tx_ready held low 5 cycles keeps the data stable; tx_ready high -> rd_done, return to IDLE.
- OUT endp 4 with page 0x0100 (MEM_DEPTH = 256) -> tran_stall, state stays IDLE; a later OUT endp 8 -> stall.
- Address phase, then no token for TIMEOUT cycles -> timeout pulse, IDLE; a subsequent IN endp 8 -> stall.
- Address phase, then OUT endp 8 with rx_bad asserted in the same cycle -> no ack, no wr_done, mem[page] unchanged, IDLE.
- Tokens to device address 3 interleaved with a full write/read to address 5 -> address-3 tokens get no response; the address-5 transfer completes normally. Assert rst_L low mid-READ_SEND -> tx_valid drops immediately.
